cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 165 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle instruction sequencer driving datapath strobes.
// Optional memory wait states enabled by defining CPU_SEQ_MEM_WAIT_EN (adds mem_ack).
module cpu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [17:0] ins,
    input  logic        cmp_true,
`ifdef CPU_SEQ_MEM_WAIT_EN
    input  logic        mem_ack,
`endif
    output logic        ir_load,
    output logic        pc_enable,
    output logic        pc_select,
    output logic        read_enable,
    output logic        alu_enable,
    output logic        imm_enable,
    output logic        comp_enable,
    output logic        ram_enable,
    output logic        st,
    output logic        mem_load,
    output logic        we,
    output logic [1:0]  aluchoice,
    output logic [2:0]  bchoice,
    output logic        ready,
    output logic [2:0]  state,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        FETCH1 = 3'b000,
        FETCH2 = 3'b001,
        EXEC   = 3'b010,
        LD2    = 3'b011,
        ST2    = 3'b100
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_opcode;
    logic [15:0] r_instr_count;
    logic        w_ack;
    logic        w_unused_ins;

`ifdef CPU_SEQ_MEM_WAIT_EN
    assign w_ack = mem_ack;
`else
    assign w_ack = 1'b1;
`endif

    assign w_unused_ins = ^ins[13:0];
    assign state        = r_state;
    assign instr_count  = r_instr_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= FETCH1;
            r_opcode      <= 4'd0;
            r_instr_count <= 16'd0;
        end else begin
            r_state <= w_next;
            if (r_state == FETCH2) begin
                r_opcode <= ins[17:14];
            end
            if (ready) begin
                r_instr_count <= r_instr_count + 16'd1;
            end
        end
    end

    always_comb begin
        ir_load     = 1'b0;
        pc_enable   = 1'b0;
        pc_select   = 1'b0;
        read_enable = 1'b0;
        alu_enable  = 1'b0;
        imm_enable  = 1'b0;
        comp_enable = 1'b0;
        ram_enable  = 1'b0;
        st          = 1'b0;
        mem_load    = 1'b0;
        we          = 1'b0;
        aluchoice   = 2'b00;
        bchoice     = 3'b000;
        ready       = 1'b0;
        w_next      = FETCH1;
        case (r_state)
            FETCH1: begin
                ram_enable = 1'b1;
                w_next     = (run && w_ack) ? FETCH2 : FETCH1;
            end
            FETCH2: begin
                ir_load   = 1'b1;
                pc_enable = 1'b1;
                w_next    = EXEC;
            end
            EXEC: begin
                if (!r_opcode[3]) begin
                    // Register and immediate ALU ops share one decode; opcode[2] picks the immediate.
                    read_enable = 1'b1;
                    alu_enable  = 1'b1;
                    we          = 1'b1;
                    aluchoice   = r_opcode[1:0];
                    imm_enable  = r_opcode[2];
                    ready       = 1'b1;
                end else begin
                    case (r_opcode)
                        4'd13: begin
                            ram_enable = 1'b1;
                            w_next     = w_ack ? LD2 : EXEC;
                        end
                        4'd14: begin
                            read_enable = 1'b1;
                            ram_enable  = 1'b1;
                            w_next      = ST2;
                        end
                        4'd15: begin
                            pc_enable = 1'b1;
                            pc_select = 1'b1;
                            ready     = 1'b1;
                        end
                        default: begin
                            read_enable = 1'b1;
                            comp_enable = 1'b1;
                            bchoice     = r_opcode[2:0];
                            pc_enable   = cmp_true;
                            pc_select   = cmp_true;
                            ready       = 1'b1;
                        end
                    endcase
                end
            end
            LD2: begin
                mem_load = 1'b1;
                we       = 1'b1;
                ready    = 1'b1;
            end
            ST2: begin
                st         = 1'b1;
                ram_enable = 1'b1;
                ready      = w_ack;
                w_next     = w_ack ? FETCH1 : ST2;
            end
            default: w_next = FETCH1;
        endcase
        // Reset overrides decode so no write strobe can escape while rst_n is low.
        if (!rst_n) begin
            ir_load     = 1'b0;
            pc_enable   = 1'b0;
            pc_select   = 1'b0;
            read_enable = 1'b0;
            alu_enable  = 1'b0;
            imm_enable  = 1'b0;
            comp_enable = 1'b0;
            ram_enable  = 1'b0;
            st          = 1'b0;
            mem_load    = 1'b0;
            we          = 1'b0;
            aluchoice   = 2'b00;
            bchoice     = 3'b000;
            ready       = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [17:0] ins = 18'd0;
    logic        cmp_true = 1'b0;
    logic        ir_load, pc_enable, pc_select, read_enable, alu_enable, imm_enable;
    logic        comp_enable, ram_enable, st, mem_load, we, ready;
    logic [1:0]  aluchoice;
    logic [2:0]  bchoice;
    logic [2:0]  state;
    logic [15:0] instr_count;
    logic [16:0] outv;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_count = 16'd0;

    typedef struct {
        logic [16:0] vec;
        logic [2:0]  st;
        int          lat;
    } exp_t;
    exp_t sb[$];

    cpu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run), .ins(ins), .cmp_true(cmp_true),
        .ir_load(ir_load), .pc_enable(pc_enable), .pc_select(pc_select),
        .read_enable(read_enable), .alu_enable(alu_enable), .imm_enable(imm_enable),
        .comp_enable(comp_enable), .ram_enable(ram_enable), .st(st), .mem_load(mem_load),
        .we(we), .aluchoice(aluchoice), .bchoice(bchoice), .ready(ready),
        .state(state), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    assign outv = {ir_load, pc_enable, pc_select, read_enable, alu_enable, imm_enable,
                   comp_enable, ram_enable, st, mem_load, we, ready, aluchoice, bchoice};

    function automatic logic [16:0] mk(input logic ir, pce, pcs, rd, alu, imm, cmp, ram,
                                       stv, ml, wev, rdy, input logic [1:0] ac,
                                       input logic [2:0] bc);
        return {ir, pce, pcs, rd, alu, imm, cmp, ram, stv, ml, wev, rdy, ac, bc};
    endfunction

    // Expected strobes in the cycle where ready is high.
    function automatic logic [16:0] ready_vec(input logic [3:0] op, input logic c);
        if (op < 4'd8)
            return mk(0, 0, 0, 1, 1, op[2], 0, 0, 0, 0, 1, 1, op[1:0], 3'b000);
        else if (op <= 4'd12)
            return mk(0, c, c, 1, 0, 0, 1, 0, 0, 0, 0, 1, 2'b00, op[2:0]);
        else if (op == 4'd13)
            return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2'b00, 3'b000);
        else if (op == 4'd14)
            return mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 2'b00, 3'b000);
        else
            return mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b000);
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Entered and left at a FETCH1 cycle, 1 time unit after the falling edge.
    task automatic do_instr(input logic [17:0] w, input logic c);
        exp_t        e;
        int          cyc;
        logic        seen_we;
        logic [3:0]  op;
        op    = w[17:14];
        e.vec = ready_vec(op, c);
        e.st  = (op == 4'd13) ? 3'b011 : (op == 4'd14) ? 3'b100 : 3'b010;
        e.lat = (op == 4'd13 || op == 4'd14) ? 4 : 3;
        sb.push_back(e);
        ins      = w;
        cmp_true = c;
        run      = 1'b1;
        #1;
        check("f1_state", state, 3'b000);
        check("f1_vec", outv, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 3'b000));
        cyc     = 1;
        seen_we = 1'b0;
        while (!ready && cyc < 10) begin
            @(negedge clk);
            #1;
            cyc++;
            if (!ready) seen_we |= we;
            if (cyc == 2)
                check("f2_vec", outv, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000));
            if (cyc == 3 && op == 4'd13)
                check("ld_exec_vec", outv, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 3'b000));
            if (cyc == 3 && op == 4'd14)
                check("st_exec_vec", outv, mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 3'b000));
        end
        if (!ready) begin
            check("ready_timeout", ready, 1'b1);
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        check("latency", cyc, e.lat);
        check("ready_state", state, e.st);
        check("ready_vec", outv, e.vec);
        check("we_before_ready", seen_we, 1'b0);
        exp_count = exp_count + 16'd1;
        @(negedge clk);
        #1;
        check("count", instr_count, exp_count);
        check("back_to_f1", state, 3'b000);
        check("ready_pulse", ready, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        run   = 1'b1;
        ins   = 18'h0A000;
        repeat (2) @(negedge clk);
        #1;
        check("rst_outs", outv, 17'd0);
        check("rst_state", state, 3'b000);
        check("rst_count", instr_count, 16'd0);

        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("idle_state", state, 3'b000);
            check("idle_ready", ready, 1'b0);
        end
        run = 1'b1;
        @(negedge clk);
        #1;
        check("run_fetch2", state, 3'b001);
        @(negedge clk);
        #1;
        check("idle_add_ready", ready, 1'b1);
        check("idle_add_alu", {alu_enable, we, aluchoice}, 4'b1110);
        exp_count = exp_count + 16'd1;
        @(negedge clk);
        #1;
        check("idle_add_count", instr_count, exp_count);

        do_instr(18'h0A000, 1'b0);
        do_instr(18'h34000, 1'b0);
        do_instr(18'h38000, 1'b0);
        do_instr(18'h20000, 1'b0);
        do_instr(18'h20000, 1'b1);
        do_instr(18'h24000, 1'b1);
        do_instr(18'h30000, 1'b0);
        do_instr(18'h10000, 1'b0);
        do_instr(18'h1C000, 1'b0);
        do_instr(18'h3C000, 1'b0);
        for (int i = 0; i < 16; i++)
            do_instr(18'($urandom), 1'($urandom_range(0, 1)));

        force dut.r_instr_count = 16'hFFFF;
        #1;
        release dut.r_instr_count;
        exp_count = 16'hFFFF;
        check("count_preload", instr_count, 16'hFFFF);
        do_instr(18'h0A000, 1'b0);

        // Abort a load in LD2 with reset.
        ins = 18'h34000;
        repeat (3) @(negedge clk);
        #1;
        check("ld2_reached", state, 3'b011);
        rst_n = 1'b0;
        #1;
        check("abort_outs", outv, 17'd0);
        check("abort_state", state, 3'b000);
        check("abort_count", instr_count, 16'd0);
        exp_count = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_state", state, 3'b000);
        do_instr(18'h0A000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
